// File: rtl/tree_pkg.sv
// Tag decoder types: wire-type and state enums, LEB128 group width, varint limits.
package tree_pkg;

    localparam int unsigned GROUP_W       = 7;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned KEY_MAX_BYTES = 5;
    localparam int unsigned LEN_MAX_BYTES = 10;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_SGROUP = 3'd3,
        WT_EGROUP = 3'd4,
        WT_I32    = 3'd5,
        WT_RSVD6  = 3'd6,
        WT_RSVD7  = 3'd7
    } wire_type_t;

    typedef enum logic [2:0] {
        KEY         = 3'd0,
        LEN         = 3'd1,
        EMIT        = 3'd2,
        SKIP_VARINT = 3'd3,
        SKIP_FIXED  = 3'd4,
        SKIP_LEN    = 3'd5,
        ERROR       = 3'd6
    } state_t;

    // States in which the decoder consumes input bytes.
    function automatic logic state_accepts(state_t s);
        return (s == KEY) || (s == LEN) || (s == SKIP_VARINT) ||
               (s == SKIP_FIXED) || (s == SKIP_LEN);
    endfunction

endpackage

// File: rtl/user_tree_pkg.sv
// Shared user-tree definitions: identifier width used by node_tree and its feeders.
package user_tree_pkg;

    localparam int unsigned IDENT_W = 16;

endpackage

// File: rtl/varint_accum.sv
// LEB128 shift-accumulator: value including the current byte, termination flag, byte count.
module varint_accum
    import tree_pkg::*;
#(
    parameter int unsigned ACC_W = 19
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en,
    input  logic [7:0]       byte_i,
    output logic [ACC_W-1:0] value_c,
    output logic             done_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned EXT_W = ACC_W + GROUP_W;
    localparam int unsigned SH_W  = 7;

    logic [ACC_W-1:0] acc;
    logic [EXT_W-1:0] group_ext;
    logic [SH_W-1:0]  shift;

    // Merge the current 7-bit group at its position; groups beyond ACC_W fall off.
    always_comb begin
        shift     = SH_W'(count) * SH_W'(GROUP_W);
        group_ext = EXT_W'(byte_i[GROUP_W-1:0]) << shift;
        value_c   = acc | group_ext[ACC_W-1:0];
        done_c    = en & ~byte_i[7];
    end

    // Terminating byte clears the state so every new varint starts from zero.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc   <= '0;
            count <= '0;
        end else if (en) begin
            if (done_c) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc <= value_c;
                if (count != '1) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/field_tag_decoder.sv
// Field tag decoder: parses key/length varints from a byte stream, emits field
// records, and skips non-nested payloads. Optional protocol checking is enabled
// with the FIELD_TAG_DECODER_ERR_CHECK_EN macro.
module field_tag_decoder
    import tree_pkg::*;
#(
    parameter int unsigned ID_W  = user_tree_pkg::IDENT_W,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid,
    output logic             byte_rdy,
    output logic [ID_W-1:0]  field_id_o,
    output logic [2:0]       wire_type_o,
    output logic [LEN_W-1:0] len_o,
    output logic             field_id_valid,
    input  logic             field_id_rdy,
    input  logic             nested_i,
    output logic             err_o
);

    localparam int unsigned ACC_W = (ID_W + 3 > LEN_W) ? ID_W + 3 : LEN_W;

    state_t           state;
    logic [LEN_W-1:0] skip_cnt;

    logic             byte_xfer_c;
    logic             acc_en_c;
    logic [ACC_W-1:0] acc_value_c;
    logic             acc_done_c;
    logic [CNT_W-1:0] acc_count;
    wire_type_t       key_wt_c;
    logic [ID_W-1:0]  key_id_c;
    logic             key_err_c;
    logic             len_err_c;

    assign byte_xfer_c = byte_valid & byte_rdy;
    assign acc_en_c    = byte_xfer_c & ((state == KEY) | (state == LEN));
    assign key_wt_c    = wire_type_t'(acc_value_c[2:0]);
    assign key_id_c    = ID_W'(acc_value_c >> 3);

    varint_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en      (acc_en_c),
        .byte_i  (byte_i),
        .value_c (acc_value_c),
        .done_c  (acc_done_c),
        .count   (acc_count)
    );

`ifdef FIELD_TAG_DECODER_ERR_CHECK_EN
    // Overlong varints and group/reserved wire types are fatal protocol errors.
    assign key_err_c = (acc_count >= CNT_W'(KEY_MAX_BYTES)) ||
                       (acc_done_c && (key_wt_c inside {WT_SGROUP, WT_EGROUP, WT_RSVD6, WT_RSVD7}));
    assign len_err_c = (acc_count >= CNT_W'(LEN_MAX_BYTES));
`else
    // Without checking, odd wire types fall through to varint skipping.
    logic unused_count;
    assign unused_count = ^acc_count;
    assign key_err_c    = 1'b0;
    assign len_err_c    = 1'b0;
`endif

    // Decoder FSM with registered handshake and record outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state          <= KEY;
            byte_rdy       <= 1'b0;
            field_id_valid <= 1'b0;
            field_id_o     <= '0;
            wire_type_o    <= '0;
            len_o          <= '0;
            err_o          <= 1'b0;
            skip_cnt       <= '0;
        end else begin
            byte_rdy <= state_accepts(state);
            case (state)
                KEY: begin
                    if (byte_xfer_c) begin
                        if (key_err_c) begin
                            state    <= ERROR;
                            byte_rdy <= 1'b0;
                            err_o    <= 1'b1;
                        end else if (acc_done_c) begin
                            field_id_o  <= key_id_c;
                            wire_type_o <= acc_value_c[2:0];
                            len_o       <= '0;
                            if (key_wt_c == WT_LEN) begin
                                state    <= LEN;
                                byte_rdy <= 1'b1;
                            end else begin
                                state          <= EMIT;
                                byte_rdy       <= 1'b0;
                                field_id_valid <= 1'b1;
                            end
                        end
                    end
                end
                LEN: begin
                    if (byte_xfer_c) begin
                        if (len_err_c) begin
                            state    <= ERROR;
                            byte_rdy <= 1'b0;
                            err_o    <= 1'b1;
                        end else if (acc_done_c) begin
                            len_o          <= LEN_W'(acc_value_c);
                            state          <= EMIT;
                            byte_rdy       <= 1'b0;
                            field_id_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (field_id_rdy) begin
                        field_id_valid <= 1'b0;
                        byte_rdy       <= 1'b1;
                        case (wire_type_t'(wire_type_o))
                            WT_I64: begin
                                state    <= SKIP_FIXED;
                                skip_cnt <= LEN_W'(8);
                            end
                            WT_I32: begin
                                state    <= SKIP_FIXED;
                                skip_cnt <= LEN_W'(4);
                            end
                            WT_LEN: begin
                                if (nested_i || (len_o == '0)) begin
                                    state <= KEY;
                                end else begin
                                    state    <= SKIP_LEN;
                                    skip_cnt <= len_o;
                                end
                            end
                            default: state <= SKIP_VARINT;
                        endcase
                    end
                end
                SKIP_VARINT: begin
                    if (byte_xfer_c && !byte_i[7]) begin
                        state <= KEY;
                    end
                end
                SKIP_FIXED, SKIP_LEN: begin
                    if (byte_xfer_c) begin
                        skip_cnt <= skip_cnt - LEN_W'(1);
                        if (skip_cnt == LEN_W'(1)) begin
                            state <= KEY;
                        end
                    end
                end
                ERROR: begin
                    byte_rdy <= 1'b0;
                end
                default: state <= KEY;
            endcase
        end
    end

endmodule

// File: doc/field_tag_decoder.md
FIELD_TAG_DECODER -- requirements
Module: field_tag_decoder

Interface
REQ-001 Parameter ID_W, default 16: width of emitted field identifier; equals width of identifier in user_tree_pkg.
REQ-002 Parameter LEN_W, default 16: width of length-delimited payload length.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 reset_i  input  1  asynchronous active-low reset.
REQ-005 byte_i  input  8  serialized message byte stream.
REQ-006 byte_valid  input  1  byte_i valid.
REQ-007 byte_rdy  output  1  decoder accepts byte_i this cycle.
REQ-008 field_id_o  output  ID_W  decoded field number, feeds node_tree field_id_i.
REQ-009 wire_type_o  output  3  decoded wire type.
REQ-010 len_o  output  LEN_W  payload length, valid only when wire_type_o==2, else 0.
REQ-011 field_id_valid  output  1  field_id_o/wire_type_o/len_o valid.
REQ-012 field_id_rdy  input  1  downstream accepts field record.
REQ-013 nested_i  input  1  downstream flag, sampled on field handshake: 1 = payload is a sub-message.
REQ-014 err_o  output  1  sticky protocol error (see Configuration).

Function
REQ-015 Byte transfer SHALL occur when byte_valid && byte_rdy; field transfer SHALL occur when field_id_valid && field_id_rdy.
REQ-016 States SHALL be KEY, LEN, EMIT, SKIP_VARINT, SKIP_FIXED, SKIP_LEN, ERROR.
REQ-017 KEY: accumulate LEB128 varint, 7 bits per byte, LSB group first; byte with bit7=0 terminates.
REQ-018 On key termination: wire_type = key[2:0], field number = key>>3 truncated to ID_W; wire type 2 -> LEN, else -> EMIT.
REQ-019 LEN: accumulate varint into length register (truncated to LEN_W); on termination -> EMIT.
REQ-020 EMIT: byte_rdy=0, field_id_valid=1; outputs SHALL remain stable until transfer.
REQ-021 field_id_valid SHALL rise the cycle after the terminating key byte (or terminating length byte) is accepted.
REQ-022 After EMIT transfer: wire 0 -> SKIP_VARINT; wire 1 -> SKIP_FIXED with count 8; wire 5 -> SKIP_FIXED with count 4; wire 2 with nested_i=1 or len=0 -> KEY; wire 2 with nested_i=0 -> SKIP_LEN with count len.
REQ-023 SKIP_VARINT: consume bytes until one with bit7=0, then -> KEY.
REQ-024 SKIP_FIXED/SKIP_LEN: decrement counter per accepted byte; on count reaching 0 -> KEY, no idle cycle.
REQ-025 byte_rdy SHALL be 1 in KEY, LEN, SKIP_* and 0 in EMIT and ERROR.
REQ-026 Accumulators SHALL clear on entry to KEY and LEN.
REQ-027 byte_valid low SHALL stall all states without state change.

Reset
REQ-028 On reset_i low, asynchronously: state=KEY, byte_rdy=0 until first clock after release, field_id_valid=0, field_id_o=0, wire_type_o=0, len_o=0, err_o=0, counters/accumulators=0.
REQ-029 Reset mid-field SHALL discard partial key, length, and pending EMIT record.

Configuration
REQ-030 Macro FIELD_TAG_DECODER_ERR_CHECK_EN defined: key varint >5 bytes, length varint >10 bytes, or wire type 3,4,6,7 SHALL set err_o and enter ERROR, which holds byte_rdy=0 until reset.
REQ-031 Macro undefined: no checks, err_o tied 0, wire types 3,4,6,7 treated as wire type 0; overlong varints keep truncating.

Structure
REQ-032 Wire-type enum, state enum, and LEB128 group width constant SHALL reside in tree_pkg; ID_W default derives from user_tree_pkg identifier.
REQ-033 One sub-module varint_accum (shift-accumulate, done flag, byte count) SHALL be instantiated for KEY and LEN.

Verification
REQ-034 Bytes 0x08,0x96,0x01, field_id_rdy=1 -> one record field_id=1, wire=0, len=0; byte_rdy returns 1 in KEY afterward.
REQ-035 Bytes 0x12,0x03,'a','b','c', nested_i=0 -> record id=2, wire=2, len=3; three bytes skipped; next byte decoded as key.
REQ-036 Bytes 0x1A,0x02,0x08,0x01, nested_i=1 -> records (3,2,len 2) then (1,0).
REQ-037 Key 0x0D then 4 bytes, field_id_rdy held 0 for 5 cycles -> outputs stable, byte_rdy=0 throughout, then id=1 wire=5, 4 bytes skipped.
REQ-038 With ERR_CHECK_EN, key 0x0B -> err_o=1 next cycle, byte_rdy=0 until reset; without, record id=1 wire=3 and varint skipped.
REQ-039 reset_i low during SKIP_LEN count 5 -> all outputs 0 immediately; after release, next byte decoded as key.
